// File: rtl/hififo_fpc_checker_if.sv
// PIO control path and from-PC FIFO head/pop bundle for the fpc stream checker.
// The master side owns the PIO bus and the FIFO head, and the slave side pops.
interface hififo_fpc_checker_if;
  logic        pio_write_valid;
  logic [12:0] pio_address;
  logic [63:0] pio_write_data;
  logic [63:0] fpc_data;
  logic        fpc_empty;
  logic        fpc_read;

  // A word moves on a clock edge where fpc_read is high and fpc_empty is low.
  // fpc_read never depends on fpc_empty, and fpc_data is first-word-fall-through.
  modport master (
    output pio_write_valid, pio_address, pio_write_data, fpc_data, fpc_empty,
    input  fpc_read
  );

  modport slave (
    input  pio_write_valid, pio_address, pio_write_data, fpc_data, fpc_empty,
    output fpc_read
  );
endinterface

// File: rtl/hififo_fpc_checker.sv
// Drains the from-PC FIFO and checks that it carries a 64-bit incrementing count.
// Keeps word and error counters and captures the first mismatch for host readback.
module hififo_fpc_checker #(
  parameter logic [12:0] CTRL_ADDR = 13'd16,
  parameter int          GAP_W     = 8
) (
  input  logic                   clock,
  input  logic                   rst_n,
  hififo_fpc_checker_if.slave    bus,
  output logic [31:0]            word_count,
  output logic [31:0]            error_count,
  output logic                   first_err_valid,
  output logic [63:0]            first_err_expected,
  output logic [63:0]            first_err_received,
  output logic                   synced,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t             state;
  logic               enable;
  logic [GAP_W-1:0]   gap;
  logic [GAP_W-1:0]   gap_cnt;
  logic [63:0]        d_q;
  logic               d_v;
  logic [63:0]        expected;

  logic ctrl_wr;
  logic clear;
  logic accept;
  logic seed;
  logic mismatch;

  assign ctrl_wr       = bus.pio_write_valid && (bus.pio_address == CTRL_ADDR);
  assign clear         = ctrl_wr && bus.pio_write_data[1];
  assign bus.fpc_read  = enable && (gap_cnt == '0) && (state != ST_IDLE);
  assign accept        = bus.fpc_read && !bus.fpc_empty;
  assign seed          = d_v && !synced;
  assign mismatch      = d_v && synced && (d_q != expected);
  assign state_dbg     = state;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      enable             <= 1'b0;
      gap                <= '0;
      gap_cnt            <= '0;
      d_q                <= '0;
      d_v                <= 1'b0;
      expected           <= '0;
      word_count         <= '0;
      error_count        <= '0;
      first_err_valid    <= 1'b0;
      first_err_expected <= '0;
      first_err_received <= '0;
      synced             <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable <= bus.pio_write_data[0];
        gap    <= bus.pio_write_data[8 +: GAP_W];
      end

      if (accept) begin
        gap_cnt <= gap;
        d_q     <= bus.fpc_data;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      if (clear) begin
        // Anything in flight or accepted on this edge is dropped uncounted.
        d_v                <= 1'b0;
        word_count         <= '0;
        error_count        <= '0;
        first_err_valid    <= 1'b0;
        first_err_expected <= '0;
        first_err_received <= '0;
        synced             <= 1'b0;
        state              <= bus.pio_write_data[0] ? ST_SYNC : ST_IDLE;
      end else begin
        d_v <= accept;

        // Seed, match and resync all continue the count from the word just seen.
        if (d_v) begin
          word_count <= word_count + 32'd1;
          expected   <= d_q + 64'd1;
        end

        if (mismatch) begin
          if (error_count != 32'hFFFF_FFFF)
            error_count <= error_count + 32'd1;
          if (!first_err_valid) begin
            first_err_valid    <= 1'b1;
            first_err_expected <= expected;
            first_err_received <= d_q;
          end
        end

        if (seed)
          synced <= 1'b1;

        case (state)
          ST_IDLE:  if (enable) state <= synced ? ST_CHECK : ST_SYNC;
          ST_SYNC:  if (!enable) state <= ST_IDLE;
                    else if (seed) state <= ST_CHECK;
          ST_CHECK: if (!enable) state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
